// File: rtl/enum_symbol_pkg.sv
// rtl/enum_symbol_pkg.sv - symbol codes, decoder states and symbol helper functions
package enum_symbol_pkg;

    typedef enum logic [1:0] {
        SYM_A = 2'd0,
        SYM_B = 2'd1,
        SYM_C = 2'd3
    } symbol_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    function automatic logic is_data(symbol_t s);
        return (s == SYM_A) || (s == SYM_B);
    endfunction

    function automatic logic sym_bit(symbol_t s);
        return s == SYM_B;
    endfunction

endpackage

// File: rtl/enum_symbol_decoder.sv
// rtl/enum_symbol_decoder.sv - decodes start-framed 2-bit symbol stream into DATA_WIDTH-bit words
//
// Optional build macro: ENUM_SYMBOL_DECODER_PARITY_EN adds an even-parity symbol after the data bits.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_sym_valid/i_sym   incoming symbol and its valid, accepted when o_sym_ready is high
//   o_sym_ready         high in every state except HOLD
//   o_data_valid/o_data decoded word, held until i_data_ready
//   i_data_ready        consumer accepts the word
//   o_err               one-cycle pulse after an offending symbol is accepted
module enum_symbol_decoder
    import enum_symbol_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sym_valid,
    output logic                  o_sym_ready,
    input  logic [1:0]            i_sym,
    output logic                  o_data_valid,
    input  logic                  i_data_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err
);

`ifdef ENUM_SYMBOL_DECODER_PARITY_EN
    // Count value at which the parity symbol is expected.
    localparam logic [CNT_WIDTH-1:0] PARITY_CNT = CNT_WIDTH'(DATA_WIDTH);
`else
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);
`endif

    state_t                state, state_n;
    logic [CNT_WIDTH-1:0]  cnt, cnt_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  valid_n;
    logic                  err_n;
    logic                  accept;
    symbol_t               sym;

    assign sym         = symbol_t'(i_sym);
    assign o_sym_ready = (state != HOLD);
    assign accept      = i_sym_valid && o_sym_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            acc          <= acc_n;
            o_data       <= data_n;
            o_data_valid <= valid_n;
            o_err        <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        data_n  = o_data;
        valid_n = o_data_valid;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sym == SYM_C) begin
                        state_n = SHIFT;
                        cnt_n   = '0;
                        acc_n   = '0;
                    end else if (!is_data(sym)) begin
                        err_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (accept) begin
                    if (sym == SYM_C) begin
                        // Resync on a new start: restart the frame in place.
                        err_n = 1'b1;
                        cnt_n = '0;
                        acc_n = '0;
                    end else if (!is_data(sym)) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                        cnt_n   = '0;
                        acc_n   = '0;
                    end else begin
`ifdef ENUM_SYMBOL_DECODER_PARITY_EN
                        if (cnt == PARITY_CNT) begin
                            // Even parity: parity bit must equal XOR of the data bits.
                            if (sym_bit(sym) == (^acc)) begin
                                data_n  = acc;
                                valid_n = 1'b1;
                                state_n = HOLD;
                            end else begin
                                err_n   = 1'b1;
                                state_n = IDLE;
                            end
                        end else begin
                            acc_n = acc | (DATA_WIDTH'(sym_bit(sym)) << cnt);
                            cnt_n = cnt + 1'b1;
                        end
`else
                        acc_n = acc | (DATA_WIDTH'(sym_bit(sym)) << cnt);
                        cnt_n = cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            data_n  = acc_n;
                            valid_n = 1'b1;
                            state_n = HOLD;
                        end
`endif
                    end
                end
            end
            HOLD: begin
                if (i_data_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_enum_symbol_decoder.sv
// tb/tb_enum_symbol_decoder.sv - self-checking bench for enum_symbol_decoder
module tb_enum_symbol_decoder;

    localparam int W = 8;
    localparam logic [1:0] A = 2'd0, B = 2'd1, C = 2'd3, X = 2'd2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sym_valid = 1'b0;
    logic         sym_ready;
    logic [1:0]   sym = 2'd0;
    logic         data_valid;
    logic         data_ready = 1'b0;
    logic [W-1:0] data;
    logic         err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int err_base;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;

    always #5 clk = ~clk;

    enum_symbol_decoder #(.DATA_WIDTH(W)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_sym_valid(sym_valid),
        .o_sym_ready(sym_ready),
        .i_sym(sym),
        .o_data_valid(data_valid),
        .i_data_ready(data_ready),
        .o_data(data),
        .o_err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard and error-pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err) err_seen++;
            if (data_valid) chk("hold_sym_ready", {31'd0, sym_ready}, 32'd0);
            if (data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, data}, 32'hFFFF_FFFF);
                end else begin
                    chk("word", {24'd0, data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic [1:0] s);
        sym_valid = 1'b1;
        sym = s;
        @(posedge clk);
        #1;
    endtask

    task automatic stop_sym();
        sym_valid = 1'b0;
        sym = A;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data bits LSB first, followed by the even-parity symbol when enabled.
    task automatic send_bits(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) send(w[i] ? B : A);
`ifdef ENUM_SYMBOL_DECODER_PARITY_EN
        send((^w) ? B : A);
`endif
    endtask

    initial begin
        // Reset state
        wait_cycles(2);
        chk("rst_sym_ready", {31'd0, sym_ready}, 32'd1);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cycles(1);

        // Frame 0xA5 with backpressure in HOLD
        err_base = err_seen;
        exp_q.push_back(8'hA5);
        send(C);
        send(B); send(A); send(B); send(A); send(A); send(B); send(A);
        chk("a5_valid_early", {31'd0, data_valid}, 32'd0);
`ifdef ENUM_SYMBOL_DECODER_PARITY_EN
        send(B);
        chk("a5_valid_before_parity", {31'd0, data_valid}, 32'd0);
        send(A);
`else
        send(B);
`endif
        stop_sym();
        chk("a5_valid_latency", {31'd0, data_valid}, 32'd1);
        chk("a5_data", {24'd0, data}, 32'hA5);
        held = data;
        for (int i = 0; i < 5; i++) begin
            wait_cycles(1);
            chk("bp_valid", {31'd0, data_valid}, 32'd1);
            chk("bp_stable", {24'd0, data}, {24'd0, held});
            chk("bp_sym_ready", {31'd0, sym_ready}, 32'd0);
        end
        data_ready = 1'b1;
        wait_cycles(1);
        chk("after_hs_valid", {31'd0, data_valid}, 32'd0);
        chk("after_hs_sym_ready", {31'd0, sym_ready}, 32'd1);
        chk("a5_no_err", err_seen - err_base, 0);

        // Illegal code mid-frame, then an all-zero frame
        err_base = err_seen;
        exp_q.push_back(8'h00);
        send(C); send(B); send(B); send(X);
        send(C); send_bits(8'h00);
        stop_sym();
        wait_cycles(3);
        chk("illegal_err_count", err_seen - err_base, 1);
        chk("illegal_drained", exp_q.size(), 0);

        // Mid-frame resync
        err_base = err_seen;
        exp_q.push_back(8'hFF);
        send(C); send(B); send(B); send(B); send(C);
        send_bits(8'hFF);
        stop_sym();
        wait_cycles(3);
        chk("resync_err_count", err_seen - err_base, 1);
        chk("resync_drained", exp_q.size(), 0);

        // Illegal code in IDLE
        err_base = err_seen;
        send(X);
        stop_sym();
        wait_cycles(2);
        chk("idle_illegal_err", err_seen - err_base, 1);

        // Asynchronous reset mid-frame, with a word left in o_data
        send(C); send(B); send(B);
        stop_sym();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sym_ready", {31'd0, sym_ready}, 32'd1);
        chk("arst_valid", {31'd0, data_valid}, 32'd0);
        chk("arst_data", {24'd0, data}, 32'd0);
        chk("arst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        err_base = err_seen;
        send(A); send(A); send(A);
        for (int i = 0; i < W; i++) send(B);
        stop_sym();
        wait_cycles(3);
        chk("nostart_valid", {31'd0, data_valid}, 32'd0);
        chk("nostart_err", err_seen - err_base, 0);
        chk("nostart_data", {24'd0, data}, 32'd0);

        // Back-to-back frames with idle gaps and ready held high
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h81);
        send(C); send_bits(8'h3C);
        stop_sym();
        wait_cycles(2);
        send(C);
        stop_sym();
        wait_cycles(2);
        send_bits(8'h81);
        stop_sym();
        wait_cycles(3);
        chk("b2b_drained", exp_q.size(), 0);

`ifdef ENUM_SYMBOL_DECODER_PARITY_EN
        // Wrong parity: error, no word
        err_base = err_seen;
        send(C);
        send(B); send(A); send(B); send(A); send(A); send(B); send(A); send(B);
        send(B);
        stop_sym();
        wait_cycles(3);
        chk("parity_bad_err", err_seen - err_base, 1);
        chk("parity_bad_valid", {31'd0, data_valid}, 32'd0);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
